// File: rtl/instruction_fetch.sv
// MIPS32 fetch stage: owns the fetch PC and IF/ID register, talks to instruction
// memory over a req/ready handshake and keeps a one-entry buffer for decode stalls.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallD,
  input  logic        pcSrcD,
  input  logic        jump,
  input  logic        clearD,
  input  logic [31:0] pcBranchD,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemRdata,
  output logic [31:0] instrD,
  output logic [31:0] pcPlus4D,
  output logic        validD
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        req;
  logic        accept;
  logic        redirect;
  logic        flush;
  logic [31:0] addr_plus4;
  logic [31:0] target;

  assign req        = (state_q == S_FETCH) || (state_q == S_DISCARD);
  assign accept     = req & imemReady;
  assign redirect   = (pcSrcD | jump) & valid_q & ~stallD;
  assign flush      = clearD & valid_q & ~stallD;
  assign addr_plus4 = addr_q + 32'd4;
  // Jump target is formed from the instruction sitting in decode, not the fetch PC.
  assign target     = pcSrcD ? pcBranchD : {pc4_q[31:28], instr_q[25:0], 2'b00};

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    pend_pc_d   = pend_pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (!stallD) begin
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
        end
        state_d = S_FETCH;
      end

      S_FETCH: begin
        if (redirect) begin
          if (accept) begin
            addr_d = target;
          end else begin
            pend_pc_d = target;
            state_d   = S_DISCARD;
          end
        end else if (accept) begin
          addr_d = addr_plus4;
          if (stallD) begin
            buf_instr_d = imemRdata;
            buf_pc4_d   = addr_plus4;
            state_d     = S_HOLD;
          end else begin
            instr_d = imemRdata;
            pc4_d   = addr_plus4;
            valid_d = 1'b1;
          end
        end else if (!stallD) begin
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
        end
      end

      S_HOLD: begin
        if (!stallD) begin
          state_d = S_FETCH;
          if (redirect) begin
            addr_d = target;
          end else begin
            instr_d = buf_instr_q;
            pc4_d   = buf_pc4_q;
            valid_d = 1'b1;
          end
        end
      end

      S_DISCARD: begin
        if (!stallD) begin
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
        end
        if (accept) begin
          addr_d  = pend_pc_q;
          state_d = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // The instruction being redirected away from must never reach execute.
    if (flush) begin
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the buffer and pending PC are reset too, so nothing from an aborted
      // request can leak out after reset even though valid bits guard them.
      state_q     <= S_IDLE;
      addr_q      <= RESET_PC;
      pend_pc_q   <= '0;
      buf_instr_q <= '0;
      buf_pc4_q   <= '0;
      instr_q     <= '0;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      addr_q      <= addr_d;
      pend_pc_q   <= pend_pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
    end
  end

  assign imemReq  = req;
  assign imemAddr = addr_q;
  assign instrD   = instr_q;
  assign pcPlus4D = pc4_q;
  assign validD   = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed test-plan sequence followed by random
// stall / wait-state / redirect traffic, checked against program-order semantics.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stallD = 1'b0, pcSrcD = 1'b0, jump = 1'b0, clearD = 1'b0;
  logic [31:0] pcBranchD = '0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady = 1'b1;
  logic [31:0] imemRdata;
  logic [31:0] instrD;
  logic [31:0] pcPlus4D;
  logic        validD;

  int checks = 0;
  int failures = 0;
  int delivered = 0;
  int gap = 0;

  // Scoreboard: PC of the next instruction decode must execute, in program order.
  logic [31:0] exp_q[$];
  logic        wait_prev = 1'b0;
  logic [31:0] addr_prev = '0;
  logic [31:0] e_pc, e_pc4, e_word, nxt;

  instruction_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stallD(stallD), .pcSrcD(pcSrcD), .jump(jump),
    .clearD(clearD), .pcBranchD(pcBranchD), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemReady(imemReady), .imemRdata(imemRdata), .instrD(instrD),
    .pcPlus4D(pcPlus4D), .validD(validD)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed jump at RST_PC+0x10, hashed words elsewhere.
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0040_0010) return 32'h0800_0010;
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  assign imemRdata = (imemReq && imemReady) ? mem(imemAddr) : 32'hBAD0_BAD0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic r, input logic b, input logic j,
                        input logic [31:0] tgt);
    stallD    = s;
    imemReady = r;
    pcSrcD    = b;
    jump      = j;
    clearD    = b | j;
    pcBranchD = tgt;
  endtask

  task automatic check_reset_outs();
    check("rst_req", imemReq, 32'd0);
    check("rst_addr", imemAddr, RST_PC);
    check("rst_instr", instrD, 32'd0);
    check("rst_pc4", pcPlus4D, 32'd0);
    check("rst_valid", validD, 32'd0);
  endtask

  task automatic restart_model();
    exp_q.delete();
    exp_q.push_back(RST_PC);
  endtask

  // Monitor: mid-cycle, every instruction decode consumes is popped and compared.
  always @(negedge clk) begin
    if (!rst_n) begin
      wait_prev = 1'b0;
      gap = 0;
    end else begin
      if (wait_prev) check("addr_stable", imemAddr, addr_prev);
      wait_prev = imemReq && !imemReady;
      addr_prev = imemAddr;
      if (!validD) check("bubble_instr", instrD, 32'd0);
      if (validD && !stallD) begin
        gap = 0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty: got pc4 %h expected none", pcPlus4D);
        end else begin
          e_pc   = exp_q.pop_front();
          e_pc4  = e_pc + 32'd4;
          e_word = mem(e_pc);
          check("dec_pc4", pcPlus4D, e_pc4);
          check("dec_instr", instrD, e_word);
          delivered++;
          if (pcSrcD)    nxt = pcBranchD;
          else if (jump) nxt = {e_pc4[31:28], e_word[25:0], 2'b00};
          else           nxt = e_pc4;
          exp_q.push_back(nxt);
        end
      end else begin
        gap++;
        if (gap > 200) begin
          checks++;
          failures++;
          $display("FAIL watchdog: got %0d idle cycles expected at most 200", gap);
          gap = 0;
        end
      end
    end
  end

  initial begin
    logic [31:0] r, tgt;
    restart_model();
    set_in(0, 1, 0, 0, '0);
    #1 rst_n = 1'b0;
    #1 check_reset_outs();
    repeat (2) step();
    rst_n = 1'b1;
    check("first_no_req", imemReq, 32'd0);
    step(); // B
    check("first_req", imemReq, 32'd1);
    check("first_addr", imemAddr, RST_PC);
    step(); // C
    check("stream_addr1", imemAddr, RST_PC + 32'h4);
    check("stream_valid", validD, 32'd1);
    check("stream_instr", instrD, mem(RST_PC));
    check("stream_pc4", pcPlus4D, RST_PC + 32'h4);
    step(); // D
    check("stream_addr2", imemAddr, RST_PC + 32'h8);
    set_in(0, 0, 0, 0, '0);
    repeat (2) begin // E, F
      step();
      check("wait_addr", imemAddr, RST_PC + 32'h8);
      check("wait_valid", validD, 32'd0);
    end
    step(); // G
    set_in(0, 1, 0, 0, '0);
    check("wait_addr_last", imemAddr, RST_PC + 32'h8);
    check("wait_valid_last", validD, 32'd0);
    step(); // H
    check("wait_instr", instrD, mem(RST_PC + 32'h8));
    check("wait_pc4", pcPlus4D, RST_PC + 32'hC);
    check("wait_next_addr", imemAddr, RST_PC + 32'hC);
    set_in(1, 1, 0, 0, '0);
    step(); // I
    check("hold_req", imemReq, 32'd0);
    check("hold_instr", instrD, mem(RST_PC + 32'h8));
    step(); // J
    set_in(0, 1, 0, 0, '0);
    check("hold_rel_req", imemReq, 32'd0);
    step(); // K
    check("rel_instr", instrD, mem(RST_PC + 32'hC));
    check("rel_pc4", pcPlus4D, RST_PC + 32'h10);
    check("rel_addr", imemAddr, RST_PC + 32'h10);
    check("rel_req", imemReq, 32'd1);
    set_in(0, 1, 1, 0, RST_PC + 32'h40);
    step(); // L
    set_in(0, 1, 0, 0, '0);
    check("br_addr", imemAddr, RST_PC + 32'h40);
    check("br_valid", validD, 32'd0);
    check("br_instr", instrD, 32'd0);
    step(); // M
    check("br_tgt_instr", instrD, mem(RST_PC + 32'h40));
    check("br_tgt_pc4", pcPlus4D, RST_PC + 32'h44);
    set_in(0, 1, 1, 0, RST_PC + 32'h10);
    step(); // N
    set_in(0, 1, 0, 0, '0);
    check("br2_addr", imemAddr, RST_PC + 32'h10);
    step(); // O
    check("jmp_instr", instrD, 32'h0800_0010);
    check("jmp_pc4", pcPlus4D, RST_PC + 32'h14);
    set_in(0, 0, 0, 1, '0);
    step(); // P
    set_in(0, 0, 0, 0, '0);
    check("disc_addr", imemAddr, RST_PC + 32'h14);
    check("disc_req", imemReq, 32'd1);
    step(); // Q
    set_in(0, 1, 0, 0, '0);
    check("disc_addr_acc", imemAddr, RST_PC + 32'h14);
    step(); // R
    check("jmp_tgt_addr", imemAddr, 32'h0000_0040);
    check("jmp_tgt_valid", validD, 32'd0);
    step(); // S
    check("jmp_tgt_instr", instrD, mem(32'h0000_0040));
    check("jmp_tgt_pc4", pcPlus4D, 32'h0000_0044);
    set_in(0, 1, 1, 0, RST_PC + 32'h10);
    step(); // T
    set_in(0, 1, 0, 0, '0);
    step(); // U
    check("jmp2_instr", instrD, 32'h0800_0010);
    set_in(1, 1, 0, 1, '0);
    step(); // V
    check("jmp_stall_req", imemReq, 32'd0);
    check("jmp_stall_instr", instrD, 32'h0800_0010);
    step(); // W
    set_in(0, 1, 0, 0, '0);
    step(); // X
    check("jmp_ign_instr", instrD, mem(RST_PC + 32'h14));
    check("jmp_ign_pc4", pcPlus4D, RST_PC + 32'h18);
    check("jmp_ign_addr", imemAddr, RST_PC + 32'h18);
    set_in(1, 1, 0, 0, '0);
    step(); // Y: in HOLD
    check("pre_rst_req", imemReq, 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_outs();
    restart_model();
    set_in(0, 1, 0, 0, '0);
    step();
    rst_n = 1'b1;
    check("rerst_no_req", imemReq, 32'd0);
    step();
    check("rerst_addr", imemAddr, RST_PC);
    check("rerst_req", imemReq, 32'd1);

    for (int i = 0; i < 4000; i++) begin
      r = $urandom;
      if (r[12:10] == 3'd0)      tgt = 32'hFFFF_FFFC;
      else if (r[15:13] == 3'd0) tgt = $urandom;
      else                       tgt = $urandom & 32'hFFFF_FFFC;
      set_in(r[1:0] == 2'd0, r[3:2] != 2'd0, r[6:4] == 3'd0, r[9:7] == 3'd0, tgt);
      if (i == 2000) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outs();
        restart_model();
        step();
        rst_n = 1'b1;
      end
      step();
    end

    set_in(0, 1, 0, 0, '0);
    step();
    check("delivered_enough", delivered > 500, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
